// File: rtl/alpharetz_spi_multimode_controller.sv
// rtl/alpharetz_spi_multimode_controller.sv - SPI controller with run-time mode, divider, length, bit order and bursts
module alpharetz_spi_multimode_controller #(
  parameter int DATA_WIDTH   = 8,
  parameter int PERI_CNT     = 4,
  parameter int P_ADDR_WIDTH = $clog2(PERI_CNT),
  parameter int DIV_WIDTH    = 8,
  parameter int LEN_WIDTH    = $clog2(DATA_WIDTH + 1)
) (
  input  logic                    sys_clk,
  input  logic                    async_rst,
  input  logic                    sys_clk_en,
  input  logic                    cfg_cpol,
  input  logic                    cfg_cpha,
  input  logic                    cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0]    cfg_clk_div,
  input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    tx_last,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [P_ADDR_WIDTH-1:0] p_addr,
  input  logic                    cipo,
  output logic                    copi,
  output logic                    p_clk,
  output logic [PERI_CNT-1:0]     p_sel_n,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    rx_valid,
  output logic                    busy
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CNT_W = LEN_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH);

  typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_XFER, ST_TRAIL, ST_WAIT} state_t;
  state_t state, state_nxt;

  logic                  cpha_q, lsb_q, last_q;
  logic [DIV_WIDTH-1:0]  div_q, div_cnt;
  logic [LEN_WIDTH-1:0]  len_q, len_in, bit_k, bit_k1;
  logic [CNT_W-1:0]      edge_cnt;
  logic [DATA_WIDTH-1:0] tx_q, rx_q;
  logic [PERI_CNT-1:0]   sel_vec;
  logic                  accept, hp_end, last_edge;

  // Position in the data word of the k-th transmitted bit for the given order
  function automatic logic [IDX_W-1:0] bit_pos(input logic [LEN_WIDTH-1:0] k,
                                               input logic [LEN_WIDTH-1:0] len,
                                               input logic lsb);
    logic [LEN_WIDTH-1:0] p;
    p = lsb ? k : (len - k - LEN_WIDTH'(1));
    return p[IDX_W-1:0];
  endfunction

  assign accept    = tx_valid & tx_ready & sys_clk_en;
  assign hp_end    = (div_cnt == div_q);
  assign last_edge = (edge_cnt == ({len_q, 1'b0} - CNT_W'(1)));
  assign bit_k     = edge_cnt[CNT_W-1:1];
  assign bit_k1    = bit_k + LEN_WIDTH'(1);
  assign len_in    = (cfg_frame_len == '0 || cfg_frame_len > MAX_LEN) ? MAX_LEN : cfg_frame_len;

  // One-hot select for the requested peripheral; out-of-range addresses select nothing
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < PERI_CNT; i++)
      if (p_addr == P_ADDR_WIDTH'(i)) sel_vec[i] = 1'b1;
  end

  // State register
  always_ff @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic; every phase is counted in enabled half-periods
  always_comb begin
    state_nxt = state;
    if (sys_clk_en) begin
      case (state)
        ST_IDLE, ST_WAIT: if (accept) state_nxt = ST_LEAD;
        ST_LEAD:          if (hp_end) state_nxt = ST_XFER;
        ST_XFER:          if (hp_end && last_edge) state_nxt = ST_TRAIL;
        ST_TRAIL:         if (hp_end) state_nxt = last_q ? ST_IDLE : ST_WAIT;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state
  always_comb begin
    busy     = (state != ST_IDLE);
    tx_ready = (state == ST_IDLE) || (state == ST_WAIT);
  end

  // Datapath: config capture, half-period timing, serial shift/sample, frame completion
  always_ff @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) begin
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      last_q   <= 1'b0;
      div_q    <= '0;
      div_cnt  <= '0;
      len_q    <= '0;
      edge_cnt <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      copi     <= 1'b0;
      p_clk    <= 1'b0;
      p_sel_n  <= '1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (sys_clk_en) begin
      rx_valid <= 1'b0;
      if (accept) begin
        cpha_q   <= cfg_cpha;
        lsb_q    <= cfg_lsb_first;
        last_q   <= tx_last;
        div_q    <= cfg_clk_div;
        len_q    <= len_in;
        tx_q     <= tx_data;
        rx_q     <= '0;
        div_cnt  <= '0;
        edge_cnt <= '0;
        p_clk    <= cfg_cpol;
        // Sample-first mode needs the first bit on the wire before the leading edge
        if (!cfg_cpha) copi <= tx_data[bit_pos('0, len_in, cfg_lsb_first)];
        // A burst keeps the chip select chosen by its first frame
        if (state == ST_IDLE) p_sel_n <= ~sel_vec;
      end else if (state == ST_LEAD || state == ST_XFER || state == ST_TRAIL) begin
        div_cnt <= hp_end ? '0 : div_cnt + DIV_WIDTH'(1);
        if (state == ST_XFER && hp_end) begin
          p_clk    <= ~p_clk;
          edge_cnt <= edge_cnt + CNT_W'(1);
          if (!edge_cnt[0]) begin
            // Leading edge
            if (!cpha_q) rx_q[bit_pos(bit_k, len_q, lsb_q)] <= cipo;
            else         copi <= tx_q[bit_pos(bit_k, len_q, lsb_q)];
          end else begin
            // Trailing edge; after the final bit copi simply holds
            if (!cpha_q) begin
              if (bit_k1 < len_q) copi <= tx_q[bit_pos(bit_k1, len_q, lsb_q)];
            end else begin
              rx_q[bit_pos(bit_k, len_q, lsb_q)] <= cipo;
            end
          end
        end
        if (state == ST_TRAIL && hp_end) begin
          rx_valid <= 1'b1;
          rx_data  <= rx_q;
          if (last_q) p_sel_n <= '1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alpharetz_spi_multimode_controller.sv
// tb/tb_alpharetz_spi_multimode_controller.sv - self-checking bench for the multimode SPI controller
module tb_alpharetz_spi_multimode_controller;
  localparam int DW = 8;

  logic       sys_clk = 1'b0;
  logic       async_rst;
  logic       sys_clk_en;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [7:0] cfg_clk_div;
  logic [3:0] cfg_frame_len;
  logic [7:0] tx_data;
  logic       tx_last, tx_valid, tx_ready;
  logic [1:0] p_addr;
  logic       cipo, copi, p_clk;
  logic [3:0] p_sel_n;
  logic [7:0] rx_data;
  logic       rx_valid, busy;
  logic       loop_mode, cipo_drv;

  int vectors = 0;
  int miscompares = 0;

  // Peripheral side: either loop copi back or drive a word from the bench model
  assign cipo = loop_mode ? copi : cipo_drv;

  always #5 sys_clk = ~sys_clk;

  alpharetz_spi_multimode_controller dut (
    .sys_clk(sys_clk), .async_rst(async_rst), .sys_clk_en(sys_clk_en),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
    .cfg_clk_div(cfg_clk_div), .cfg_frame_len(cfg_frame_len),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .p_addr(p_addr), .cipo(cipo), .copi(copi), .p_clk(p_clk), .p_sel_n(p_sel_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [3:0] fl);
    return (fl == 4'd0 || int'(fl) > DW) ? DW : int'(fl);
  endfunction

  // k-th bit on the wire comes from this word position
  function automatic int bit_pos(input int k, input int len, input logic lsb);
    return lsb ? k : (len - 1 - k);
  endfunction

  function automatic logic get_bit(input logic [7:0] w, input int p);
    logic [7:0] t;
    t = w >> p;
    return t[0];
  endfunction

  // Runs one frame as an SPI peripheral would see it. Called right after a negedge.
  task automatic do_frame(input string tag, input logic cpol, input logic cpha, input logic lsb,
                          input logic [7:0] div, input logic [3:0] flen, input logic [7:0] data,
                          input logic last, input logic [1:0] addr, input logic [3:0] exp_cs,
                          input logic [7:0] pat, input bit loop, input bit gate);
    int len, lat, cycles, en_cycles, rises, lead_n, trail_n;
    logic [7:0] cap, mask, exp_rx;
    logic prev_clk, en_now;
    bit cs_ok, seen;
    len    = eff_len(flen);
    mask   = 8'((1 << len) - 1);
    lat    = (2 * len + 2) * (int'(div) + 1);
    exp_rx = (loop ? data : pat) & mask;

    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
    cfg_clk_div = div; cfg_frame_len = flen;
    tx_data = data; tx_last = last; p_addr = addr;
    tx_valid = 1'b1; sys_clk_en = 1'b1;
    loop_mode = loop;
    cipo_drv = get_bit(pat, bit_pos(0, len, lsb));
    @(posedge sys_clk);
    @(negedge sys_clk);
    tx_valid = 1'b0;
    // Everything presented at accept is latched; scramble it now
    cfg_cpol = 1'($urandom); cfg_cpha = 1'($urandom); cfg_lsb_first = 1'($urandom);
    cfg_clk_div = 8'($urandom); cfg_frame_len = 4'($urandom);
    tx_data = 8'($urandom); tx_last = 1'($urandom); p_addr = 2'($urandom);

    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
    check({tag, "_cs_acc"}, 32'(p_sel_n), 32'(exp_cs));
    check({tag, "_pclk_lead"}, 32'(p_clk), 32'(cpol));

    cycles = 0; en_cycles = 0; rises = 0; lead_n = 0; trail_n = 0;
    cap = '0; cs_ok = 1; seen = 0; prev_clk = p_clk;
    en_now = gate ? 1'b0 : 1'b1;
    sys_clk_en = en_now;
    while (!seen && cycles < 4000) begin
      @(negedge sys_clk);
      cycles++;
      if (en_now) en_cycles++;
      if (rx_valid) seen = 1;
      else begin
        if (p_sel_n !== exp_cs) cs_ok = 0;
        if (p_clk !== prev_clk) begin
          if (p_clk) rises++;
          if (p_clk !== cpol) begin
            if (!cpha) cap |= 8'(copi) << bit_pos(lead_n, len, lsb);
            else       cipo_drv = get_bit(pat, bit_pos(lead_n, len, lsb));
            lead_n++;
          end else begin
            if (cpha) cap |= 8'(copi) << bit_pos(trail_n, len, lsb);
            else if (trail_n + 1 < len) cipo_drv = get_bit(pat, bit_pos(trail_n + 1, len, lsb));
            trail_n++;
          end
          prev_clk = p_clk;
        end
        if (gate) en_now = ~en_now;
        sys_clk_en = en_now;
      end
    end

    check({tag, "_rxv_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, en_cycles, lat);
    if (gate) check({tag, "_gated_cycles"}, cycles, 2 * lat);
    check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "_copi_word"}, 32'(cap), 32'(data & mask));
    check({tag, "_rises"}, rises, len);
    check({tag, "_pclk_idle"}, 32'(p_clk), 32'(cpol));
    check({tag, "_cs_held"}, 32'(cs_ok), 32'd1);
    check({tag, "_cs_end"}, 32'(p_sel_n), last ? 32'hF : 32'(exp_cs));
    check({tag, "_busy_end"}, 32'(busy), last ? 32'd0 : 32'd1);
    sys_clk_en = 1'b1;
    @(negedge sys_clk);
    check({tag, "_rxv_pulse"}, 32'(rx_valid), 32'd0);
    check({tag, "_ready_end"}, 32'(tx_ready), 32'd1);
  endtask

  int  n, rises_r, gap;
  bit  ok, rxv_seen;
  logic prev;
  logic [1:0] ra;

  initial begin
    async_rst = 1'b1; sys_clk_en = 1'b1;
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb_first = 0; cfg_clk_div = 0; cfg_frame_len = 0;
    tx_data = 0; tx_last = 0; tx_valid = 0; p_addr = 0; loop_mode = 0; cipo_drv = 0;
    repeat (2) @(negedge sys_clk);
    check("rst_copi", 32'(copi), 32'd0);
    check("rst_pclk", 32'(p_clk), 32'd0);
    check("rst_csn", 32'(p_sel_n), 32'hF);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    check("rst_rxvalid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    async_rst = 1'b0;
    @(negedge sys_clk);

    // Mode 0, loopback
    do_frame("m0_loop", 0, 0, 0, 8'd0, 4'd8, 8'hA5, 1, 2'd0, 4'hE, 8'h00, 1, 0);
    // Mode 3, LSB-first, cipo held high
    do_frame("m3_lsb", 1, 1, 1, 8'd2, 4'd5, 8'h13, 1, 2'd1, 4'hD, 8'hFF, 0, 0);

    // Burst with a gap in WAIT; second frame's address must be ignored
    do_frame("burst_a", 0, 0, 0, 8'd0, 4'd8, 8'h11, 0, 2'd2, 4'hB, 8'h5C, 0, 0);
    ok = 1;
    for (gap = 0; gap < 10; gap++) begin
      @(negedge sys_clk);
      if (p_sel_n !== 4'hB || p_clk !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) ok = 0;
    end
    check("burst_gap", 32'(ok), 32'd1);
    do_frame("burst_b", 0, 0, 0, 8'd0, 4'd8, 8'h22, 1, 2'd0, 4'hB, 8'hC3, 0, 0);

    // Out-of-range frame lengths fall back to full width
    do_frame("len0", 0, 1, 0, 8'd0, 4'd0, 8'h96, 1, 2'd3, 4'h7, 8'h3A, 0, 0);
    do_frame("len12", 1, 0, 1, 8'd0, 4'd12, 8'h69, 1, 2'd0, 4'hE, 8'hE1, 0, 0);

    // Mode 1 with clock enable toggling every cycle
    do_frame("gated", 0, 1, 0, 8'd0, 4'd8, 8'hB4, 1, 2'd1, 4'hD, 8'h4B, 0, 1);

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      ra = 2'($urandom);
      do_frame($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom),
               1'b1, ra, ~(4'b0001 << ra), 8'($urandom), 1'($urandom), 0);
    end

    // Asynchronous reset in the middle of a frame
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb_first = 0; cfg_clk_div = 8'd1; cfg_frame_len = 4'd8;
    tx_data = 8'h5A; tx_last = 1; p_addr = 2'd1; loop_mode = 1; tx_valid = 1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    tx_valid = 0;
    rises_r = 0; n = 0; prev = p_clk;
    while (rises_r < 4 && n < 500) begin
      @(negedge sys_clk);
      n++;
      if (p_clk && !prev) rises_r++;
      prev = p_clk;
    end
    check("midrst_reached", rises_r, 4);
    check("midrst_busy_pre", 32'(busy), 32'd1);
    #2 async_rst = 1'b1;
    #1;
    check("midrst_csn", 32'(p_sel_n), 32'hF);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pclk", 32'(p_clk), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    @(negedge sys_clk);
    async_rst = 1'b0;
    rxv_seen = 0;
    repeat (60) begin
      @(negedge sys_clk);
      if (rx_valid) rxv_seen = 1;
    end
    check("midrst_no_rxv", 32'(rxv_seen), 32'd0);
    check("midrst_idle_csn", 32'(p_sel_n), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
